// File: rtl/mmcm_lock_sequencer.sv
// rtl/mmcm_lock_sequencer.sv - MMCM reset/lock sequencer with timeout, bounded retry, settle and status LED
module mmcm_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYC = 16,
    parameter int unsigned LOCK_TIMEOUT = 5_000_000,
    parameter int unsigned SETTLE_CYC   = 1000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned BLINK_SLOW   = 25_000_000,
    parameter int unsigned BLINK_FAST   = 6_250_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       mmcm_locked,
    input  logic       relock_req,
    output logic       mmcm_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fail,
    output logic       lost_lock,
    output logic [3:0] retry_cnt,
    output logic       status_led
);

    typedef enum logic [2:0] {
        ST_RESET_HOLD,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        LED_ACQ,
        LED_RUN,
        LED_FAIL
    } led_mode_t;

    localparam logic [31:0] HOLD_LAST    = 32'(RST_HOLD_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] SLOW_LAST    = 32'(BLINK_SLOW - 1);
    localparam logic [31:0] FAST_LAST    = 32'(BLINK_FAST - 1);
    localparam logic [3:0]  RETRY_LAST   = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        sync1_q, sync2_q;
    logic        lock_s;

    led_mode_t   mode_q, mode_d;
    logic [31:0] led_cnt_q, led_cnt_d;
    logic [31:0] half_last;
    logic        led_q, led_d;

    logic        mmcm_rst_q, mmcm_rst_d;
    logic        core_rst_q, core_rst_d;
    logic        ready_q, ready_d;
    logic        fail_q, fail_d;
    logic        lost_q, lost_d;

    assign lock_s = sync2_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        case (state_q)
            ST_RESET_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // lock is checked first so it wins a tie with the timeout
                if (lock_s) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LAST) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_RESET_HOLD;
                    end
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                retry_d = 4'd0;
                if (!lock_s) begin
                    lost_d  = 1'b1;
                    state_d = ST_RESET_HOLD;
                end else if (relock_req) begin
                    state_d = ST_RESET_HOLD;
                end
            end
            ST_FAIL: begin
                if (relock_req) begin
                    state_d = ST_RESET_HOLD;
                    retry_d = 4'd0;
                end
            end
            default: state_d = ST_RESET_HOLD;
        endcase

        cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;

        // outputs are decoded from the next state so they move with the state register
        mmcm_rst_d = (state_d == ST_RESET_HOLD) || (state_d == ST_FAIL);
        core_rst_d = (state_d != ST_RUN);
        ready_d    = (state_d == ST_RUN);
        fail_d     = (state_d == ST_FAIL);
    end

    always_comb begin
        mode_d    = LED_ACQ;
        led_cnt_d = 32'd0;
        led_d     = led_q;
        if (state_d == ST_RUN)       mode_d = LED_RUN;
        else if (state_d == ST_FAIL) mode_d = LED_FAIL;
        half_last = (mode_d == LED_FAIL) ? FAST_LAST : SLOW_LAST;

        if (mode_d != mode_q) begin
            led_d = (mode_d == LED_RUN);
        end else if (mode_d == LED_RUN) begin
            led_d = 1'b1;
        end else if (led_cnt_q == half_last) begin
            led_d = ~led_q;
        end else begin
            led_cnt_d = led_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_RESET_HOLD;
            cnt_q      <= 32'd0;
            retry_q    <= 4'd0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            mode_q     <= LED_ACQ;
            led_cnt_q  <= 32'd0;
            led_q      <= 1'b0;
            mmcm_rst_q <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            sync1_q    <= mmcm_locked;
            sync2_q    <= sync1_q;
            mode_q     <= mode_d;
            led_cnt_q  <= led_cnt_d;
            led_q      <= led_d;
            mmcm_rst_q <= mmcm_rst_d;
            core_rst_q <= core_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
            lost_q     <= lost_d;
        end
    end

    assign mmcm_rst   = mmcm_rst_q;
    assign core_rst   = core_rst_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign lost_lock  = lost_q;
    assign retry_cnt  = retry_q;
    assign status_led = led_q;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// tb/tb_mmcm_lock_sequencer.sv - self-checking bench for mmcm_lock_sequencer
module tb_mmcm_lock_sequencer;

    localparam int RH = 4;
    localparam int TO = 20;
    localparam int ST = 8;
    localparam int MR = 2;
    localparam int BS = 5;
    localparam int BF = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       mmcm_locked;
    logic       relock_req;
    logic       mmcm_rst;
    logic       core_rst;
    logic       ready;
    logic       fail;
    logic       lost_lock;
    logic [3:0] retry_cnt;
    logic       status_led;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    mmcm_lock_sequencer #(
        .RST_HOLD_CYC(RH),
        .LOCK_TIMEOUT(TO),
        .SETTLE_CYC  (ST),
        .MAX_RETRY   (MR),
        .BLINK_SLOW  (BS),
        .BLINK_FAST  (BF)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mmcm_locked(mmcm_locked),
        .relock_req (relock_req),
        .mmcm_rst   (mmcm_rst),
        .core_rst   (core_rst),
        .ready      (ready),
        .fail       (fail),
        .lost_lock  (lost_lock),
        .retry_cnt  (retry_cnt),
        .status_led (status_led)
    );

    // Vector order: mmcm_rst, core_rst, ready, fail, lost_lock, retry_cnt[3:0], status_led
    function automatic logic [9:0] obs();
        return {mmcm_rst, core_rst, ready, fail, lost_lock, retry_cnt, status_led};
    endfunction

    function automatic logic [9:0] mk(input bit m, input bit c, input bit r, input bit f,
                                      input bit l, input int rc, input bit led);
        logic [3:0] rc4;
        rc4 = rc[3:0];
        return {m, c, r, f, l, rc4, led};
    endfunction

    function automatic bit blink(input int since, input int half);
        return ((since / half) % 2) == 1;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Leaves the bench just after edge 0, the last edge that samples sys_rst=1.
    task automatic do_reset();
        sys_rst     = 1'b1;
        mmcm_locked = 1'b0;
        relock_req  = 1'b0;
        repeat (3) step();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        logic [9:0] got;
        int n;
        n = $urandom_range(3, 6);
        sys_rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            mmcm_locked = 1'($urandom_range(0, 1));
            relock_req  = 1'($urandom_range(0, 1));
            step();
            exp = mk(1, 1, 0, 0, 0, 0, 0);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset i=%0d got=%b want=%b", i, got, exp);
            end
        end
    endtask

    // Lock is first sampled d edges after mmcm_rst falls; stray relock requests must be ignored.
    task automatic test_acquire(input int d);
        logic [9:0] exp;
        logic [9:0] got;
        int e0, t;
        e0 = RH + 1 + d;
        t  = e0 + ST + 2;
        do_reset();
        for (int k = 1; k <= t + 3; k++) begin
            mmcm_locked = (k >= e0);
            relock_req  = (k <= t) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            exp = mk(k < RH, k < t, k >= t, 0, 0, 0, (k < t) ? blink(k, BS) : 1'b1);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL acquire d=%0d k=%0d got=%b want=%b", d, k, got, exp);
            end
        end
        relock_req = 1'b0;
    endtask

    task automatic test_fail();
        logic [9:0] exp;
        logic [9:0] got;
        int period, fail_at, f;
        bit m, fl, led;
        int rc;
        period  = RH + TO;
        fail_at = (MR + 1) * period;
        f       = fail_at + $urandom_range(1, 10);
        do_reset();
        for (int k = 1; k <= f + RH + 2; k++) begin
            mmcm_locked = 1'b0;
            relock_req  = (k <= fail_at) ? 1'($urandom_range(0, 1)) : (k == f);
            step();
            if (k < fail_at) begin
                m = (k % period) < RH; fl = 0; rc = k / period; led = blink(k, BS);
            end else if (k < f) begin
                m = 1; fl = 1; rc = MR; led = blink(k - fail_at, BF);
            end else begin
                m = (k - f) < RH; fl = 0; rc = 0; led = blink(k - f, BS);
            end
            exp = mk(m, 1, 0, fl, 0, rc, led);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timeout_fail k=%0d got=%b want=%b", k, got, exp);
            end
        end
        relock_req = 1'b0;
    endtask

    // Lock drops for 3 sampled cycles, a edges after it first appeared.
    task automatic test_settle_drop(input int d, input int a);
        logic [9:0] exp;
        logic [9:0] got;
        int e0, t;
        e0 = RH + 1 + d;
        t  = e0 + a + 3 + ST + 2;
        do_reset();
        for (int k = 1; k <= t + 2; k++) begin
            mmcm_locked = (k >= e0) && !(k >= e0 + a && k < e0 + a + 3);
            relock_req  = 1'b0;
            step();
            exp = mk(k < RH, k < t, k >= t, 0, 0, 0, (k < t) ? blink(k, BS) : 1'b1);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL settle_drop d=%0d a=%0d k=%0d got=%b want=%b", d, a, k, got, exp);
            end
        end
    endtask

    // In RUN, relock_req arrives on the edge where the lock loss is seen (or alone if drop=0).
    task automatic test_run_exit(input int d, input int w, input bit drop);
        logic [9:0] exp;
        logic [9:0] got;
        int e0, t, l, q;
        bit led;
        e0 = RH + 1 + d;
        t  = e0 + ST + 2;
        l  = t + w;
        q  = l + 2;
        do_reset();
        for (int k = 1; k <= q + RH + 3; k++) begin
            mmcm_locked = (k >= e0) && (!drop || k < l);
            relock_req  = (k == q);
            step();
            if (k < t)      led = blink(k, BS);
            else if (k < q) led = 1'b1;
            else            led = blink(k - q, BS);
            exp = mk((k < RH) || (k >= q && k < q + RH), (k < t) || (k >= q),
                     (k >= t) && (k < q), 0, drop && (k == q), 0, led);
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL run_exit drop=%0d k=%0d got=%b want=%b", drop, k, got, exp);
            end
        end
        relock_req = 1'b0;
    endtask

    task automatic test_rst_mid_settle(input int d, input int ro);
        logic [9:0] exp;
        logic [9:0] got;
        int e0, r;
        e0 = RH + 1 + d;
        r  = e0 + 2 + ro;
        do_reset();
        for (int k = 1; k <= r + RH; k++) begin
            sys_rst     = (k == r);
            mmcm_locked = (k >= e0);
            relock_req  = 1'b0;
            step();
            if (k < r)       exp = mk(k < RH, 1, 0, 0, 0, 0, blink(k, BS));
            else if (k == r) exp = mk(1, 1, 0, 0, 0, 0, 0);
            else             exp = mk((k - r) < RH, 1, 0, 0, 0, 0, blink(k - r, BS));
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rst_mid_settle k=%0d got=%b want=%b", k, got, exp);
            end
        end
        sys_rst = 1'b0;
    endtask

    initial begin
        sys_rst     = 1'b1;
        mmcm_locked = 1'b0;
        relock_req  = 1'b0;

        test_reset();
        test_acquire(0);
        test_acquire(10);
        test_acquire(TO - 3);
        repeat (3) test_acquire($urandom_range(1, TO - 4));
        test_fail();
        test_settle_drop($urandom_range(0, 6), 1);
        test_settle_drop($urandom_range(0, 6), ST);
        repeat (2) test_settle_drop($urandom_range(0, 6), $urandom_range(2, ST - 1));
        repeat (3) test_run_exit($urandom_range(0, 8), $urandom_range(1, 6), 1'b1);
        test_run_exit($urandom_range(0, 8), $urandom_range(1, 6), 1'b0);
        test_rst_mid_settle($urandom_range(0, 6), 1);
        test_rst_mid_settle($urandom_range(0, 6), $urandom_range(2, ST - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
